wb_write_arbiter: RTL

- Shares the single register-file write port (writeEnable/writeAddress/writeData) between two writeback sources: A (ALU result path) and B (memory/load return path).
- Each source has a valid/ready handshake and a one-entry holding buffer.
- When both buffers are full, a round-robin pointer picks the winner.
- The winning entry is driven to the register file from registered outputs. A pending-destination mask is exported so the issue stage can stall on read-after-write hazards.

---
 rtl/wb_write_arbiter_if.sv | 56 +++++
 rtl/wb_write_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/wb_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_write_arbiter_if
//   Bundle for the shared register-file write port. It carries the two
//   writeback source handshakes (A = ALU result, B = load return), the
//   registered write port and the pending-destination mask.
//
//   modport slave  : the arbiter side. It takes the source offers and drives
//                    the ready signals, the write port and pendingMask.
//   modport master : the environment side. It drives the source offers and
//                    observes everything else.
//
//   Signals
//     aValid/aAddr/aData  source A offer
//     aReady              source A accepted at this edge if aValid
//     bValid/bAddr/bData  source B offer
//     bReady              source B accepted at this edge if bValid
//     writeEnable         register-file write strobe (registered)
//     writeAddress        register-file write address (registered)
//     writeData           register-file write data (registered)
//     pendingMask         one bit per register with a write still in flight
// ---------------------------------------------------------------------------
interface wb_write_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic                     aValid;
    logic [ADDR_W-1:0]        aAddr;
    logic [DATA_W-1:0]        aData;
    logic                     aReady;

    logic                     bValid;
    logic [ADDR_W-1:0]        bAddr;
    logic [DATA_W-1:0]        bData;
    logic                     bReady;

    logic                     writeEnable;
    logic [ADDR_W-1:0]        writeAddress;
    logic [DATA_W-1:0]        writeData;
    logic [(2**ADDR_W)-1:0]   pendingMask;

    modport slave (
        input  aValid, aAddr, aData,
        input  bValid, bAddr, bData,
        output aReady, bReady,
        output writeEnable, writeAddress, writeData,
        output pendingMask
    );

    modport master (
        output aValid, aAddr, aData,
        output bValid, bAddr, bData,
        input  aReady, bReady,
        input  writeEnable, writeAddress, writeData,
        input  pendingMask
    );
endinterface

// File: rtl/wb_write_arbiter.sv
// ---------------------------------------------------------------------------
// wb_write_arbiter
//   Two writeback sources share one register-file write port. Each source
//   has a one-entry holding buffer. When both buffers hold an entry, a
//   round-robin pointer picks the winner. The granted entry goes out through
//   registered writeEnable/writeAddress/writeData. pendingMask flags every
//   register that is targeted by a buffered entry or by the output stage, so
//   that issue can stall on read-after-write hazards.
//
//   Ports
//     clk    system clock, rising edge
//     reset  asynchronous, active-high
//     bus    wb_write_arbiter_if.slave (handshakes, write port, mask)
//
//   Round-robin pointer
//     state | meaning
//     PTR_A | A wins the next contended cycle (B was served last, or reset)
//     PTR_B | B wins the next contended cycle (A was served last)
// ---------------------------------------------------------------------------
module wb_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    wb_write_arbiter_if.slave  bus
);

    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {
        PTR_A = 1'b0,
        PTR_B = 1'b1
    } rr_ptr_e;

    rr_ptr_e               rr_ptr_q, rr_ptr_d;

    logic                  buf_a_valid_q, buf_a_valid_d;
    logic [ADDR_W-1:0]     buf_a_addr_q,  buf_a_addr_d;
    logic [DATA_W-1:0]     buf_a_data_q,  buf_a_data_d;

    logic                  buf_b_valid_q, buf_b_valid_d;
    logic [ADDR_W-1:0]     buf_b_addr_q,  buf_b_addr_d;
    logic [DATA_W-1:0]     buf_b_data_q,  buf_b_data_d;

    logic                  wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]     wr_data_q, wr_data_d;

    logic                  grant_a;
    logic                  grant_b;
    logic                  a_ready;
    logic                  b_ready;
    logic                  a_accept;
    logic                  b_accept;
    logic [DEPTH-1:0]      pending_mask;

    // Arbitration uses buffer state at the start of the cycle only, so the
    // ready signals do not depend on the incoming valids.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (buf_a_valid_q && buf_b_valid_q) begin
            grant_a = (rr_ptr_q == PTR_A);
            grant_b = (rr_ptr_q == PTR_B);
        end else begin
            grant_a = buf_a_valid_q;
            grant_b = buf_b_valid_q;
        end
    end

    // A buffer that drains this cycle can take a new entry at the same
    // edge. This lets a continuously granted source stream one entry per
    // cycle.
    assign a_ready  = !buf_a_valid_q || grant_a;
    assign b_ready  = !buf_b_valid_q || grant_b;
    assign a_accept = bus.aValid && a_ready;
    assign b_accept = bus.bValid && b_ready;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_a) begin
            rr_ptr_d = PTR_B;
        end else if (grant_b) begin
            rr_ptr_d = PTR_A;
        end
    end

    always_comb begin
        buf_a_valid_d = buf_a_valid_q;
        buf_a_addr_d  = buf_a_addr_q;
        buf_a_data_d  = buf_a_data_q;
        if (a_accept) begin
            buf_a_valid_d = 1'b1;
            buf_a_addr_d  = bus.aAddr;
            buf_a_data_d  = bus.aData;
        end else if (grant_a) begin
            buf_a_valid_d = 1'b0;
        end
    end

    always_comb begin
        buf_b_valid_d = buf_b_valid_q;
        buf_b_addr_d  = buf_b_addr_q;
        buf_b_data_d  = buf_b_data_q;
        if (b_accept) begin
            buf_b_valid_d = 1'b1;
            buf_b_addr_d  = bus.bAddr;
            buf_b_data_d  = bus.bData;
        end else if (grant_b) begin
            buf_b_valid_d = 1'b0;
        end
    end

    // Address and data follow every grant, including those to register 0.
    // Only the strobe is suppressed for register 0, because it is hardwired
    // to zero. With no grant, address and data hold their values.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (grant_a) begin
            wr_en_d   = (buf_a_addr_q != '0);
            wr_addr_d = buf_a_addr_q;
            wr_data_d = buf_a_data_q;
        end else if (grant_b) begin
            wr_en_d   = (buf_b_addr_q != '0);
            wr_addr_d = buf_b_addr_q;
            wr_data_d = buf_b_data_q;
        end
    end

    always_comb begin
        pending_mask = '0;
        if (buf_a_valid_q && (buf_a_addr_q != '0)) begin
            pending_mask[buf_a_addr_q] = 1'b1;
        end
        if (buf_b_valid_q && (buf_b_addr_q != '0)) begin
            pending_mask[buf_b_addr_q] = 1'b1;
        end
        if (wr_en_q && (wr_addr_q != '0)) begin
            pending_mask[wr_addr_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q      <= PTR_A;
            buf_a_valid_q <= 1'b0;
            buf_a_addr_q  <= '0;
            buf_a_data_q  <= '0;
            buf_b_valid_q <= 1'b0;
            buf_b_addr_q  <= '0;
            buf_b_data_q  <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            buf_a_valid_q <= buf_a_valid_d;
            buf_a_addr_q  <= buf_a_addr_d;
            buf_a_data_q  <= buf_a_data_d;
            buf_b_valid_q <= buf_b_valid_d;
            buf_b_addr_q  <= buf_b_addr_d;
            buf_b_data_q  <= buf_b_data_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
        end
    end

    assign bus.aReady       = a_ready;
    assign bus.bReady       = b_ready;
    assign bus.writeEnable  = wr_en_q;
    assign bus.writeAddress = wr_addr_q;
    assign bus.writeData    = wr_data_q;
    assign bus.pendingMask  = pending_mask;

endmodule
